// File: rtl/lane_line_averager.sv
// Averages the valid left-lane Hough candidates (rho/theta) captured on a done
// rising edge and writes one packed line word into a downstream FIFO.
module lane_line_averager #(
  parameter int unsigned THETA_UNROLL = 2,
  parameter int unsigned NUM_LANES    = 8,
  parameter int unsigned RHO_WIDTH    = 16,
  parameter int unsigned THETA_WIDTH  = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic hough_done,
  input  logic [THETA_UNROLL-1:0][$clog2(NUM_LANES/THETA_UNROLL)-1:0] left_index_in,
  input  logic [THETA_UNROLL-1:0][NUM_LANES/THETA_UNROLL-1:0][RHO_WIDTH-1:0] left_rhos_in,
  input  logic [THETA_UNROLL-1:0][NUM_LANES/THETA_UNROLL-1:0][THETA_WIDTH-1:0] left_thetas_in,
  output logic        out_wr_en,
  input  logic        out_full,
  output logic [31:0] out_din,
  output logic        busy
);

  localparam int unsigned LPG     = NUM_LANES / THETA_UNROLL;
  localparam int unsigned IDX_W   = $clog2(LPG);
  localparam int unsigned CNT_LOG = $clog2(NUM_LANES);
  localparam int unsigned SUM_W   = RHO_WIDTH + CNT_LOG;
  localparam int unsigned TSUM_W  = THETA_WIDTH + CNT_LOG;
  localparam int unsigned CNT_W   = CNT_LOG + 1;
  localparam int unsigned G_W     = (THETA_UNROLL > 1) ? $clog2(THETA_UNROLL) : 1;
  localparam int unsigned DCNT_W  = $clog2(SUM_W);

  typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, WRITE} state_t;

  state_t state, state_next;

  logic done_q;
  logic start;

  logic [THETA_UNROLL-1:0][IDX_W-1:0]                   idx_q;
  logic [THETA_UNROLL-1:0][LPG-1:0][RHO_WIDTH-1:0]      rho_q;
  logic [THETA_UNROLL-1:0][LPG-1:0][THETA_WIDTH-1:0]    theta_q;

  logic [G_W-1:0]    g;
  logic [IDX_W-1:0]  k;
  logic [SUM_W-1:0]  rho_sum;
  logic [TSUM_W-1:0] theta_sum;
  logic [CNT_W-1:0]  count;

  logic [SUM_W-1:0]  rho_num, rho_rem, theta_num, theta_rem;
  logic [DCNT_W-1:0] dcnt;

  logic              slot_valid, last_slot, div_last;
  logic [SUM_W-1:0]  rho_acc;
  logic [TSUM_W-1:0] theta_acc;
  logic [CNT_W-1:0]  cnt_acc;
  logic [SUM_W-1:0]  divisor;
  logic [SUM_W-1:0]  rho_trial, theta_trial;
  logic              rho_ge, theta_ge;
  logic [SUM_W-1:0]  rho_rem_n, rho_num_n, theta_rem_n, theta_num_n;

  assign start     = hough_done & ~done_q & (state == IDLE);
  assign out_wr_en = (state == WRITE) & ~out_full;

  // Accumulate step for the current slot and one restoring-divide step.
  always_comb begin
    slot_valid  = (k < idx_q[g]);
    last_slot   = (g == G_W'(THETA_UNROLL - 1)) && (k == IDX_W'(LPG - 1));
    div_last    = (dcnt == DCNT_W'(SUM_W - 1));
    rho_acc     = rho_sum + (slot_valid ? SUM_W'(rho_q[g][k]) : '0);
    theta_acc   = theta_sum + (slot_valid ? TSUM_W'(theta_q[g][k]) : '0);
    cnt_acc     = count + CNT_W'(slot_valid);
    divisor     = SUM_W'(count);
    rho_trial   = {rho_rem[SUM_W-2:0], rho_num[SUM_W-1]};
    theta_trial = {theta_rem[SUM_W-2:0], theta_num[SUM_W-1]};
    rho_ge      = (rho_trial >= divisor);
    theta_ge    = (theta_trial >= divisor);
    rho_rem_n   = rho_ge ? (rho_trial - divisor) : rho_trial;
    theta_rem_n = theta_ge ? (theta_trial - divisor) : theta_trial;
    rho_num_n   = {rho_num[SUM_W-2:0], rho_ge};
    theta_num_n = {theta_num[SUM_W-2:0], theta_ge};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ACCUM;
      ACCUM:   if (last_slot) state_next = (cnt_acc == '0) ? WRITE : DIVIDE;
      DIVIDE:  if (div_last) state_next = WRITE;
      WRITE:   if (!out_full) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture, accumulation, division and output word registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done_q    <= 1'b0;
      busy      <= 1'b0;
      out_din   <= '0;
      idx_q     <= '0;
      rho_q     <= '0;
      theta_q   <= '0;
      g         <= '0;
      k         <= '0;
      rho_sum   <= '0;
      theta_sum <= '0;
      count     <= '0;
      rho_num   <= '0;
      rho_rem   <= '0;
      theta_num <= '0;
      theta_rem <= '0;
      dcnt      <= '0;
    end else begin
      done_q <= hough_done;
      busy   <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            idx_q     <= left_index_in;
            rho_q     <= left_rhos_in;
            theta_q   <= left_thetas_in;
            g         <= '0;
            k         <= '0;
            rho_sum   <= '0;
            theta_sum <= '0;
            count     <= '0;
          end
        end
        ACCUM: begin
          rho_sum   <= rho_acc;
          theta_sum <= theta_acc;
          count     <= cnt_acc;
          if (k == IDX_W'(LPG - 1)) begin
            k <= '0;
            g <= g + G_W'(1);
          end else begin
            k <= k + IDX_W'(1);
          end
          if (last_slot) begin
            rho_num   <= rho_acc;
            theta_num <= SUM_W'(theta_acc);
            rho_rem   <= '0;
            theta_rem <= '0;
            dcnt      <= '0;
            if (cnt_acc == '0) out_din <= '0;
          end
        end
        DIVIDE: begin
          rho_num   <= rho_num_n;
          rho_rem   <= rho_rem_n;
          theta_num <= theta_num_n;
          theta_rem <= theta_rem_n;
          dcnt      <= dcnt + DCNT_W'(1);
          if (div_last)
            out_din <= 32'({1'b1, rho_num_n[RHO_WIDTH-1:0], theta_num_n[THETA_WIDTH-1:0]});
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lane_line_averager.sv
// Directed scoreboard bench for lane_line_averager: expected line words and
// write latencies are queued at start and matched on each FIFO write.
module tb_lane_line_averager;

  localparam int unsigned TU  = 2;
  localparam int unsigned NL  = 8;
  localparam int unsigned RW  = 16;
  localparam int unsigned TW  = 8;
  localparam int unsigned LPG = NL / TU;

  localparam logic [31:0] W_NOM   = 32'h0100_621F; // valid, rho 98, theta 31
  localparam logic [31:0] W_TRUNC = 32'h0100_0A2D; // valid, rho 10, theta 45
  localparam logic [31:0] W_ZERO  = 32'h0000_0000;

  logic clock = 1'b0;
  logic reset;
  logic hough_done;
  logic [TU-1:0][$clog2(LPG)-1:0] left_index_in;
  logic [TU-1:0][LPG-1:0][RW-1:0] left_rhos_in;
  logic [TU-1:0][LPG-1:0][TW-1:0] left_thetas_in;
  logic        out_wr_en;
  logic        out_full;
  logic [31:0] out_din;
  logic        busy;

  lane_line_averager #(.THETA_UNROLL(TU), .NUM_LANES(NL), .RHO_WIDTH(RW), .THETA_WIDTH(TW)) dut (
    .clock(clock), .reset(reset), .hough_done(hough_done),
    .left_index_in(left_index_in), .left_rhos_in(left_rhos_in), .left_thetas_in(left_thetas_in),
    .out_wr_en(out_wr_en), .out_full(out_full), .out_din(out_din), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] word;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int cyc = 0;
  int t0 = 0;
  int writes = 0;
  int passed = 0;
  int failed = 0;
  int total = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write monitor: each accepted write is matched against the scoreboard head.
  always @(negedge clock) begin : mon
    exp_t e;
    if (out_wr_en === 1'b1) begin
      writes++;
      if (sbq.size() == 0) begin
        chk("unexpected_write", out_din, 32'hDEAD_BEEF);
      end else begin
        e = sbq.pop_front();
        chk("write_word", out_din, e.word);
        chk("write_latency", 32'(cyc + 1 - t0), 32'(e.lat));
      end
    end
  end

  task automatic fill_junk();
    for (int g = 0; g < TU; g++)
      for (int k = 0; k < LPG; k++) begin
        left_rhos_in[g][k]   = RW'(16'h7000 + 16'(g * 16 + k));
        left_thetas_in[g][k] = TW'(8'hC0 + 8'(g * 8 + k));
      end
  endtask

  task automatic load_nominal();
    fill_junk();
    left_index_in[0] = 2'd2;
    left_index_in[1] = 2'd1;
    left_rhos_in[0][0] = 16'd100; left_thetas_in[0][0] = 8'd30;
    left_rhos_in[0][1] = 16'd104; left_thetas_in[0][1] = 8'd32;
    left_rhos_in[1][0] = 16'd90;  left_thetas_in[1][0] = 8'd31;
  endtask

  task automatic load_trunc();
    fill_junk();
    left_index_in[0] = 2'd2;
    left_index_in[1] = 2'd0;
    left_rhos_in[0][0] = 16'd10; left_thetas_in[0][0] = 8'd45;
    left_rhos_in[0][1] = 16'd11; left_thetas_in[0][1] = 8'd46;
  endtask

  task automatic load_zero();
    fill_junk();
    left_index_in[0] = 2'd0;
    left_index_in[1] = 2'd0;
  endtask

  // Raise hough_done so edge T is the next posedge; returns just after edge T.
  task automatic start_run(input logic [31:0] w, input int lat, input bit push);
    @(negedge clock);
    hough_done = 1'b1;
    @(posedge clock);
    #1;
    t0 = cyc;
    if (push) sbq.push_back('{word: w, lat: lat});
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clock);
    hough_done = 1'b0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_idle_in_time"}, 32'(n < 200), 32'd1);
    chk({tag, "_scoreboard_drained"}, 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    reset = 1'b1;
    hough_done = 1'b0;
    out_full = 1'b0;
    left_index_in = '0;
    fill_junk();
    repeat (3) @(negedge clock);
    chk("reset_wr_en", 32'(out_wr_en), 32'd0);
    chk("reset_din", out_din, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Nominal run; inputs change right after capture and must not matter.
    load_nominal();
    start_run(W_NOM, 28, 1'b1);
    @(negedge clock);
    chk("nominal_busy_t1", 32'(busy), 32'd1);
    load_trunc();
    wait_idle("nominal");

    // Truncated quotient.
    load_trunc();
    start_run(W_TRUNC, 28, 1'b1);
    wait_idle("trunc");

    // Zero candidates: no divide phase.
    load_zero();
    start_run(W_ZERO, 9, 1'b1);
    wait_idle("zero");

    // Backpressure holding the output word.
    load_nominal();
    out_full = 1'b1;
    start_run(W_NOM, 41, 1'b1);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (i == 2) hough_done = 1'b0;
      if (i >= 28) begin
        chk("bp_wr_en_low", 32'(out_wr_en), 32'd0);
        chk("bp_din_stable", out_din, W_NOM);
      end
    end
    @(posedge clock);
    #1 out_full = 1'b0;
    @(negedge clock);
    chk("bp_busy_t41", 32'(busy), 32'd1);
    @(negedge clock);
    chk("bp_busy_t42", 32'(busy), 32'd0);
    chk("bp_scoreboard_drained", 32'(sbq.size()), 32'd0);

    // Level start with a re-trigger edge during ACCUM.
    load_nominal();
    w0 = writes;
    start_run(W_NOM, 28, 1'b1);
    for (int i = 1; i <= 100; i++) begin
      @(negedge clock);
      if (i == 3) hough_done = 1'b0;
      if (i == 5) hough_done = 1'b1;
    end
    chk("level_busy_low", 32'(busy), 32'd0);
    chk("level_single_write", 32'(writes - w0), 32'd1);
    hough_done = 1'b0;
    repeat (3) @(negedge clock);
    load_trunc();
    start_run(W_TRUNC, 28, 1'b1);
    wait_idle("level_second");

    // Reset in the middle of DIVIDE.
    load_nominal();
    w0 = writes;
    start_run(W_NOM, 28, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clock);
      if (i == 2) hough_done = 1'b0;
    end
    chk("midrst_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_wr_en", 32'(out_wr_en), 32'd0);
    chk("midrst_din", out_din, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    chk("midrst_no_write", 32'(writes - w0), 32'd0);
    start_run(W_NOM, 28, 1'b1);
    wait_idle("after_reset");

    chk("final_scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lane_line_averager.md
Name: lane_line_averager

Overview:
- Downstream consumer of the Hough top level.
- On the Hough `done` rising edge it latches the per-group left-lane candidate lists (index, rhos, thetas).
- It scans every slot and accumulates the valid rho/theta values, then divides by the valid count with a sequential restoring divider.
- It pushes one averaged left-lane line word into a standard write-side FIFO (wr_en/full) for the line-overlay stage.

Parameters:
- THETA_UNROLL, 2, number of candidate groups (matches Hough unroll)
- NUM_LANES, 8, total candidate slots; LANES_PER_GROUP = NUM_LANES/THETA_UNROLL
- RHO_WIDTH, 16, unsigned rho width
- THETA_WIDTH, 8, unsigned theta width

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous active-high reset
- hough_done  in  1  Hough completion level; rising edge starts a run
- left_index_in  in  THETA_UNROLL x $clog2(LANES_PER_GROUP)  per-group valid count; slots 0..index-1 are valid
- left_rhos_in  in  THETA_UNROLL x LANES_PER_GROUP x RHO_WIDTH  candidate rhos
- left_thetas_in  in  THETA_UNROLL x LANES_PER_GROUP x THETA_WIDTH  candidate thetas
- out_wr_en  out  1  FIFO write strobe
- out_full  in  1  FIFO full
- out_din  out  32  line word: [31:25]=0, [24]=line_valid, [23:8]=rho_avg, [7:0]=theta_avg
- busy  out  1  high from capture until the write is accepted

Behaviour:
- Reset, asynchronous and immediate:
  - out_wr_en=0, out_din=0, busy=0.
  - State=IDLE; all sums, counts, divider registers and done_q=0.
- Start condition:
  - Registered done_q; start = hough_done & ~done_q, detected only in IDLE.
  - A rising edge in any other state is ignored.
  - hough_done held high yields exactly one run.
- States:
  - IDLE:
    - On start (edge T), copy all input arrays into internal registers and clear the sums and count.
    - busy=1 from T+1. Go to ACCUM.
  - ACCUM:
    - Slot pointer (g,k) walks g=0..THETA_UNROLL-1, k=0..LANES_PER_GROUP-1, one slot per cycle, exactly NUM_LANES cycles.
    - If k < index[g]: rho_sum += rho, theta_sum += theta, count += 1.
    - After the last slot: count==0 goes to WRITE with line_valid=0 and rho/theta=0; otherwise go to DIVIDE.
  - DIVIDE:
    - Two parallel unsigned restoring dividers (rho_sum/count, theta_sum/count), one quotient bit per cycle.
    - SUM_W = RHO_WIDTH+$clog2(NUM_LANES) cycles (19 by default); the theta divider is zero-extended to SUM_W.
    - Quotient is truncated, never rounded. Go to WRITE with line_valid=1.
  - WRITE:
    - out_din is held stable.
    - out_wr_en = ~out_full, combinationally from state; the write is accepted when out_wr_en=1.
    - On acceptance: go to IDLE, busy=0 next cycle.
    - While out_full=1: stay, out_wr_en=0, out_din unchanged, no timeout.
- Widths:
  - rho_sum is SUM_W bits and theta_sum is THETA_WIDTH+$clog2(NUM_LANES) bits, so no overflow is possible.
  - Quotients are at most the max input, so truncation to RHO_WIDTH/THETA_WIDTH is lossless.
  - count is $clog2(NUM_LANES)+1 bits.
- Latency:
  - With start at edge T, ACCUM occupies T+1..T+NUM_LANES.
  - DIVIDE occupies the next SUM_W cycles.
  - First out_wr_en is asserted in cycle T+1+NUM_LANES+SUM_W (T+28 default); the zero-count case asserts at T+1+NUM_LANES.
- Input arrays may change after capture without affecting the run.
- An index value ≥ LANES_PER_GROUP cannot occur, because of the port width.
- Reset mid-run aborts immediately; no partial word is written, and the next start behaves normally.

Test Plan:
- Nominal average:
  - Stimulus: index={2,1}, group0 rhos={100,104}, thetas={30,32}; group1 rho={90}, theta={31}; hough_done rises at T.
  - Required: a single write at T+28 with out_din = {valid=1, rho=98, theta=31}.
- Truncation:
  - Stimulus: index={2,0}, rhos={10,11}, thetas={45,46}.
  - Required: rho=10, theta=45, valid=1.
- Zero candidates:
  - Stimulus: index={0,0}.
  - Required: write at T+9 with out_din=0x00000000 (valid=0); no DIVIDE cycles.
- Backpressure:
  - Stimulus: out_full=1 from T through T+40, then 0.
  - Required: out_wr_en=0 throughout while out_din is stable; exactly one write at T+41; busy drops at T+42.
- Level start / retrigger:
  - Stimulus: hough_done held high for 100 cycles; a second pulse arrives at T+5 during ACCUM.
  - Required: exactly one write; the second pulse is ignored.
  - A fresh rising edge after busy=0 yields a second correct write.
- Reset mid-DIVIDE:
  - Stimulus: assert reset at T+15.
  - Required: all outputs 0 asynchronously; no write.
  - After release, a new run with the nominal data writes rho=98, theta=31.
